// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared encodings and default address map for the program-counter block.
//   - next-PC select encodings (PC_SEL_*)
//   - halt cause encodings (HALT_*)
//   - FSM state type
//   - default instruction-memory window and trap vector
package pc_unit_pkg;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_ABS  = 2'b01;  // absolute tgt
    localparam logic [1:0] PC_SEL_REL  = 2'b10;  // PC + signed tgt
    localparam logic [1:0] PC_SEL_TRAP = 2'b11;  // trap vector

    localparam logic [1:0] HALT_NONE  = 2'b00;
    localparam logic [1:0] HALT_RANGE = 2'b01;
    localparam logic [1:0] HALT_ALIGN = 2'b10;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } pc_state_e;

    localparam logic [31:0] PC_IMEM_BASE  = 32'h0100_0000;
    localparam logic [31:0] PC_IMEM_LIMIT = 32'h0100_0FFC;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0100_0000;
    localparam logic [31:0] PC_TRAP_ADDR  = 32'h0100_0F00;

endpackage

// File: rtl/pc_trace_buf.sv
// pc_trace_buf: circular buffer of redirect records, most recent first on read.
// Ports:
//   clk, rst    clock, asynchronous active-low reset (clears all entries)
//   wr_en       record wr_data this cycle
//   wr_data     {source PC, target PC}
//   rd_idx      0 = newest entry, higher = older
//   rd_data     selected entry (0 if never written)
module pc_trace_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [2*ADDR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [2*ADDR_W-1:0] rd_data
);

    logic [2*ADDR_W-1:0] mem_q [DEPTH];
    logic [2*ADDR_W-1:0] mem_d [DEPTH];
    logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]    rd_ptr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + IDX_W'(1);
        end
    end

    // wr_ptr points at the next free slot; DEPTH is a power of two so the
    // subtraction wraps around the ring naturally.
    assign rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign rd_data = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: RV32 program counter with sequential/absolute/relative/trap updates,
// same-edge range and alignment checking, sticky halt with cause, resume and
// a saturating accepted-update counter.
// Optional redirect trace buffer enabled by defining PC_TRACE_EN.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   en           update request
//   sel, tgt     next-PC mode and target/offset
//   resume       leave HALTED, restart at RESET_ADDR
//   inst_addr    registered fetch address
//   next_addr    combinational candidate next PC
//   halt         high in HALTED
//   halt_cause   reason for the halt
//   upd_cnt      accepted update count (saturating)
//   trace_idx    trace read index (PC_TRACE_EN)
//   trace_data   {source PC, target PC} (PC_TRACE_EN, else 0)
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE   = ADDR_W'(PC_IMEM_BASE),
    parameter logic [ADDR_W-1:0] IMEM_LIMIT  = ADDR_W'(PC_IMEM_LIMIT),
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR),
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = ADDR_W'(PC_TRAP_ADDR),
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [1:0]                     sel,
    input  logic [ADDR_W-1:0]              tgt,
    input  logic                           resume,
    output logic [ADDR_W-1:0]              inst_addr,
    output logic [ADDR_W-1:0]              next_addr,
    output logic                           halt,
    output logic [1:0]                     halt_cause,
    output logic [CNT_W-1:0]               upd_cnt,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [2*ADDR_W-1:0]            trace_data
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
    logic [1:0]        halt_cause_q, halt_cause_d;
    logic [CNT_W-1:0]  upd_cnt_q, upd_cnt_d;
    logic              accept;
    logic              misaligned;
    logic              out_of_range;

    // Modulo-2^ADDR_W arithmetic; wrap-around is left to the range check.
    always_comb begin
        next_addr = inst_addr_q + ADDR_W'(4);
        unique case (sel)
            PC_SEL_SEQ:  next_addr = inst_addr_q + ADDR_W'(4);
            PC_SEL_ABS:  next_addr = tgt;
            PC_SEL_REL:  next_addr = inst_addr_q + tgt;
            PC_SEL_TRAP: next_addr = TRAP_ADDR;
        endcase
    end

    assign misaligned   = (next_addr[1:0] != 2'b00);
    assign out_of_range = (next_addr < IMEM_BASE) || (next_addr > IMEM_LIMIT);

    always_comb begin
        state_d      = state_q;
        inst_addr_d  = inst_addr_q;
        halt_cause_d = halt_cause_q;
        upd_cnt_d    = upd_cnt_q;
        accept       = 1'b0;
        case (state_q)
            StRun: begin
                if (en) begin
                    // Alignment is checked first so it wins when both apply.
                    if (misaligned) begin
                        state_d      = StHalted;
                        halt_cause_d = HALT_ALIGN;
                    end else if (out_of_range) begin
                        state_d      = StHalted;
                        halt_cause_d = HALT_RANGE;
                    end else begin
                        accept      = 1'b1;
                        inst_addr_d = next_addr;
                        if (upd_cnt_q != {CNT_W{1'b1}}) begin
                            upd_cnt_d = upd_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            StHalted: begin
                // en is ignored here, so resume always wins.
                if (resume) begin
                    state_d      = StRun;
                    inst_addr_d  = RESET_ADDR;
                    halt_cause_d = HALT_NONE;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            inst_addr_q  <= RESET_ADDR;
            halt_cause_q <= HALT_NONE;
            upd_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            inst_addr_q  <= inst_addr_d;
            halt_cause_q <= halt_cause_d;
            upd_cnt_q    <= upd_cnt_d;
        end
    end

    assign inst_addr  = inst_addr_q;
    assign halt       = (state_q == StHalted);
    assign halt_cause = halt_cause_q;
    assign upd_cnt    = upd_cnt_q;

`ifdef PC_TRACE_EN
    logic trace_wr;
    assign trace_wr = accept && (sel != PC_SEL_SEQ);

    pc_trace_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (trace_wr),
        .wr_data ({inst_addr_q, next_addr}),
        .rd_idx  (trace_idx),
        .rd_data (trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_idx, accept};
    assign trace_data   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit. A second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        resume;
    logic [2:0]  trace_idx;
    logic [31:0] inst_addr, next_addr;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [31:0] upd_cnt;
    logic [63:0] trace_data;

    logic [31:0] s_inst_addr, s_next_addr;
    logic        s_halt;
    logic [1:0]  s_halt_cause;
    logic [1:0]  s_upd_cnt;
    logic [63:0] s_trace_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel        (sel),
        .tgt        (tgt),
        .resume     (resume),
        .inst_addr  (inst_addr),
        .next_addr  (next_addr),
        .halt       (halt),
        .halt_cause (halt_cause),
        .upd_cnt    (upd_cnt),
        .trace_idx  (trace_idx),
        .trace_data (trace_data)
    );

    pc_unit #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel        (sel),
        .tgt        (tgt),
        .resume     (resume),
        .inst_addr  (s_inst_addr),
        .next_addr  (s_next_addr),
        .halt       (s_halt),
        .halt_cause (s_halt_cause),
        .upd_cnt    (s_upd_cnt),
        .trace_idx  (trace_idx),
        .trace_data (s_trace_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] s, input logic [31:0] t,
                         input logic r);
        en     = e;
        sel    = s;
        tgt    = t;
        resume = r;
    endtask

    initial begin
        rst = 1'b0;
        trace_idx = '0;
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b0);
        #12;
        check("rst_inst", 64'(inst_addr), 64'h0100_0000);
        check("rst_halt", 64'(halt), 64'h0);
        check("rst_cause", 64'(halt_cause), 64'h0);
        check("rst_cnt", 64'(upd_cnt), 64'h0);
        check("rst_next_seq", 64'(next_addr), 64'h0100_0004);
        check("rst_trace", trace_data, 64'h0);
        rst = 1'b1;

        // Sequential run
        drive(1'b1, PC_SEL_SEQ, 32'h0, 1'b0);
        step(); check("seq1", 64'(inst_addr), 64'h0100_0004);
        step(); check("seq2", 64'(inst_addr), 64'h0100_0008);
        step(); check("seq3", 64'(inst_addr), 64'h0100_000C);
        check("seq_cnt", 64'(upd_cnt), 64'd3);
        check("seq_halt", 64'(halt), 64'h0);
        check("sat_cnt3", 64'(s_upd_cnt), 64'd3);
        step(); check("seq4", 64'(inst_addr), 64'h0100_0010);
        check("sat_hold", 64'(s_upd_cnt), 64'd3);

        // Relative backward jump, then a wrap below the window
        drive(1'b1, PC_SEL_REL, 32'hFFFF_FFF0, 1'b0);
        #1; check("rel_next", 64'(next_addr), 64'h0100_0000);
        step(); check("rel_inst", 64'(inst_addr), 64'h0100_0000);
        check("rel_cnt", 64'(upd_cnt), 64'd5);
        drive(1'b1, PC_SEL_REL, 32'hFFFF_FFFC, 1'b0);
        #1; check("rel_under_next", 64'(next_addr), 64'h00FF_FFFC);
        step(); check("under_halt", 64'(halt), 64'h1);
        check("under_cause", 64'(halt_cause), 64'(HALT_RANGE));
        check("under_inst", 64'(inst_addr), 64'h0100_0000);
        check("under_cnt", 64'(upd_cnt), 64'd5);

        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b1);
        step(); check("res1_halt", 64'(halt), 64'h0);

        // Misaligned absolute target
        drive(1'b1, PC_SEL_ABS, 32'h0100_0102, 1'b0);
        step(); check("mis_halt", 64'(halt), 64'h1);
        check("mis_cause", 64'(halt_cause), 64'(HALT_ALIGN));
        check("mis_inst", 64'(inst_addr), 64'h0100_0000);
        drive(1'b1, PC_SEL_ABS, 32'h0100_0100, 1'b0);
        step(); check("halted_en_inst", 64'(inst_addr), 64'h0100_0000);
        check("halted_en_halt", 64'(halt), 64'h1);
        check("halted_en_cnt", 64'(upd_cnt), 64'd5);
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b1);
        step(); check("res2_inst", 64'(inst_addr), 64'h0100_0000);
        check("res2_halt", 64'(halt), 64'h0);
        check("res2_cause", 64'(halt_cause), 64'(HALT_NONE));
        check("res2_cnt", 64'(upd_cnt), 64'd5);

        // Upper boundary
        drive(1'b1, PC_SEL_ABS, 32'h0100_0FFC, 1'b0);
        step(); check("lim_inst", 64'(inst_addr), 64'h0100_0FFC);
        check("lim_cnt", 64'(upd_cnt), 64'd6);
        drive(1'b1, PC_SEL_SEQ, 32'h0, 1'b0);
        step(); check("lim_halt", 64'(halt), 64'h1);
        check("lim_cause", 64'(halt_cause), 64'(HALT_RANGE));
        check("lim_inst_hold", 64'(inst_addr), 64'h0100_0FFC);

        // resume beats en in HALTED
        drive(1'b1, PC_SEL_TRAP, 32'h0, 1'b1);
        #1; check("trap_next", 64'(next_addr), 64'h0100_0F00);
        step(); check("res_en_inst", 64'(inst_addr), 64'h0100_0000);
        check("res_en_halt", 64'(halt), 64'h0);
        check("res_en_cnt", 64'(upd_cnt), 64'd6);
        drive(1'b1, PC_SEL_TRAP, 32'h0, 1'b0);
        step(); check("trap_inst", 64'(inst_addr), 64'h0100_0F00);
        check("trap_cnt", 64'(upd_cnt), 64'd7);

        // Misaligned and out of range together: alignment wins
        drive(1'b1, PC_SEL_ABS, 32'h0000_0001, 1'b0);
        step(); check("prio_cause", 64'(halt_cause), 64'(HALT_ALIGN));
        check("prio_inst", 64'(inst_addr), 64'h0100_0F00);
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b1);
        step();
        drive(1'b1, PC_SEL_SEQ, 32'h0, 1'b0);
        step(); check("seq5", 64'(inst_addr), 64'h0100_0004);
        check("seq5_cnt", 64'(upd_cnt), 64'd8);

        // resume ignored in RUN, en=0 holds
        drive(1'b0, PC_SEL_ABS, 32'h0100_0200, 1'b1);
        step(); check("run_res_inst", 64'(inst_addr), 64'h0100_0004);
        check("run_res_cnt", 64'(upd_cnt), 64'd8);
        check("run_res_halt", 64'(halt), 64'h0);
        check("sat_final", 64'(s_upd_cnt), 64'd3);

`ifdef PC_TRACE_EN
        trace_idx = 3'd0;
        #1; check("tr_pre_rst", trace_data, {32'h0100_0000, 32'h0100_0F00});
`endif

        // Asynchronous reset mid-run
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b0);
        rst = 1'b0;
        #1; check("arst_inst", 64'(inst_addr), 64'h0100_0000);
        check("arst_cnt", 64'(upd_cnt), 64'd0);
        trace_idx = 3'd0;
        #1; check("arst_trace", trace_data, 64'h0);
        rst = 1'b1;

`ifdef PC_TRACE_EN
        drive(1'b1, PC_SEL_ABS, 32'h0100_0040, 1'b0);
        step();
        drive(1'b1, PC_SEL_ABS, 32'h0100_0080, 1'b0);
        step();
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b0);
        trace_idx = 3'd0;
        #1; check("tr_idx0", trace_data, {32'h0100_0040, 32'h0100_0080});
        trace_idx = 3'd1;
        #1; check("tr_idx1", trace_data, {32'h0100_0000, 32'h0100_0040});
        trace_idx = 3'd2;
        #1; check("tr_idx2", trace_data, 64'h0);
`else
        drive(1'b1, PC_SEL_ABS, 32'h0100_0040, 1'b0);
        step();
        drive(1'b0, PC_SEL_SEQ, 32'h0, 1'b0);
        check("abs_inst", 64'(inst_addr), 64'h0100_0040);
        trace_idx = 3'd1;
        #1; check("no_trace", trace_data, 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the RV32 core; successor to the single-mode PC.
- Holds the fetch address and supports sequential, absolute, PC-relative and trap-vector updates.
- Checks range and alignment on the target being written in the same edge, so there is no one-cycle-stale check.
- Provides a sticky halt with a cause code, a software-visible resume, and an accepted-update counter; drives instruction-memory fetch and the control unit.

Parameters:
- ADDR_W, 32, address width in bits.
- IMEM_BASE, 32'h0100_0000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0100_0FFC, highest legal fetch address (inclusive).
- RESET_ADDR, 32'h0100_0000, PC value after reset and after resume.
- TRAP_ADDR, 32'h0100_0F00, target when sel=11.
- CNT_W, 32, width of the accepted-update counter.
- TRACE_DEPTH, 8, redirect-trace entries (power of 2, only used with PC_TRACE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  update request from the control unit (one update per cycle when high).
- sel  in  2  next-PC mode: 00 = PC+4, 01 = absolute tgt, 10 = PC+tgt (signed, two's complement), 11 = TRAP_ADDR.
- tgt  in  ADDR_W  absolute target or signed offset.
- resume  in  1  leave HALTED, restart at RESET_ADDR.
- inst_addr  out  ADDR_W  current fetch address (registered).
- next_addr  out  ADDR_W  combinational candidate next PC for the current sel/tgt.
- halt  out  1  high while in HALTED.
- halt_cause  out  2  00 none, 01 out-of-range, 10 misaligned.
- upd_cnt  out  CNT_W  number of accepted PC updates.
- trace_idx  in  log2(TRACE_DEPTH)  trace read index (PC_TRACE_EN only).
- trace_data  out  2*ADDR_W  {source PC, target PC} (PC_TRACE_EN only).

Behaviour:
- Reset (rst=0, async):
  - inst_addr=RESET_ADDR, state=RUN, halt=0, halt_cause=00, upd_cnt=0, trace cleared.
  - Reset asserted mid-operation overrides everything immediately.
- FSM states: RUN, HALTED.
- next_addr is combinational from inst_addr, sel and tgt:
  - Arithmetic is modulo 2^ADDR_W; wrap-around is not trapped arithmetically and is caught by the range check.
  - For sel=01, tgt is used unmodified; the LSBs are not cleared.
- RUN, en=1, evaluated on the rising edge:
  - If next_addr[1:0]!=0: go to HALTED, halt_cause=10, inst_addr holds, upd_cnt holds.
  - Else if next_addr<IMEM_BASE or next_addr>IMEM_LIMIT (unsigned): go to HALTED, halt_cause=01, inst_addr holds.
  - Misaligned takes priority over out-of-range when both apply.
  - Else: inst_addr<=next_addr, upd_cnt<=upd_cnt+1.
- Counter saturation: upd_cnt saturates at all-ones; it never wraps.
- Latency: an accepted update is visible on inst_addr one cycle after the en edge. halt rises on the same edge that rejects the update.
- RUN, en=0: everything holds. resume is ignored in RUN.
- HALTED:
  - en is ignored; inst_addr stays at the last legal PC.
  - resume=1: inst_addr<=RESET_ADDR, state=RUN, halt=0, halt_cause=00; upd_cnt is kept.
  - resume and en high in the same cycle: resume wins, and en is not applied that cycle.
- Sequential update at IMEM_LIMIT: PC+4 is out of range, so the block halts with cause 01.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined:
  - A circular buffer of TRACE_DEPTH entries records {inst_addr, next_addr} on every accepted update with sel!=00. Rejected updates are not recorded.
  - trace_idx=0 reads the most recent entry; higher indices read older entries.
  - Entries not yet written read 0. The buffer is cleared on reset; resume does not clear it.
  - The buffer overwrites the oldest entry when full.
- Not defined: trace_idx is unused, trace_data ties to 0, and no buffer storage is built.

Decomposition:
- Shared package/header:
  - sel encodings (PC_SEL_SEQ, PC_SEL_ABS, PC_SEL_REL, PC_SEL_TRAP).
  - halt_cause encodings (HALT_NONE, HALT_RANGE, HALT_ALIGN).
  - FSM state encodings.
  - Default IMEM_BASE, IMEM_LIMIT and TRAP_ADDR constants.
- Sub-module: pc_trace_buf, the circular trace buffer, instantiated only under PC_TRACE_EN.

Test Plan:
- Reset, then en=1, sel=00 for 3 cycles -> inst_addr 0x0100_0000 → 0x0100_0004 → 0x0100_0008 → 0x0100_000C; upd_cnt=3; halt=0.
- PC=0x0100_0010, sel=10, tgt=0xFFFF_FFF0 -> inst_addr=0x0100_0000. Then sel=10, tgt=0xFFFF_FFFC -> halt=1, cause=01, inst_addr stays 0x0100_0000.
- sel=01, tgt=0x0100_0102 -> halt=1, cause=10, inst_addr unchanged. A further en=1 has no effect. resume=1 -> inst_addr=0x0100_0000, halt=0, cause=00.
- sel=01, tgt=0x0100_0FFC, then sel=00 -> the first update is accepted; the second gives halt=1, cause=01, inst_addr stays 0x0100_0FFC.
- In HALTED, resume=1 and en=1 with sel=11 in the same cycle -> inst_addr=RESET_ADDR, not TRAP_ADDR. The next sel=11 update -> inst_addr=0x0100_0F00.
- With PC_TRACE_EN: from PC 0x0100_0000, redirect to 0x0100_0040 then 0x0100_0080 -> trace_idx=0 reads {0x0100_0040, 0x0100_0080}; idx=1 reads {0x0100_0000, 0x0100_0040}; idx=2 reads 0. Asserting rst mid-run clears the trace and returns inst_addr to 0x0100_0000 immediately.
